// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and scoreboard for a 2R/1W register file (r0 hardwired 0).
// Shares the single write port between the WB stage and a long-latency unit (LU)
// through a one-entry hold buffer with starvation protection, and tracks registers
// with pending LU results so ID can be stalled on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int unsigned MAX_LONG   = 4,  // max outstanding LU ops (1..15)
  parameter int unsigned STARVE_MAX = 3   // WB wins tolerated before forcing the buffer
) (
  input  logic        clk,
  input  logic        clrn,
  // ID stage
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic        id_use_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rt_i,
  input  logic        id_wr_i,
  input  logic [4:0]  id_wn_i,
  input  logic        id_long_i,
  output logic        id_stall_o,
  // WB stage
  input  logic        wb_we_i,
  input  logic [4:0]  wb_wn_i,
  input  logic [31:0] wb_d_i,
  output logic        pipe_hold_o,
  // Long-latency unit
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_wn_i,
  input  logic [31:0] lu_d_i,
  output logic        lu_ready_o,
  // Register file write port
  output logic        rf_we_o,
  output logic [4:0]  rf_wn_o,
  output logic [31:0] rf_d_o
);

  localparam int unsigned CW = $clog2(MAX_LONG + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_LONG);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // buffer empty
    S_PEND  = 2'd1,  // buffer holds a result, competing with WB
    S_FORCE = 2'd2   // buffer starved too long, WB frozen for one cycle
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    busy_q, busy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [4:0]     buf_wn_q;
  logic [31:0]    buf_d_q;

  logic wb_live;
  logic capture;
  logic commit;
  logic issue;
  logic hazard;

  // WB only really writes when it targets a non-zero register.
  assign wb_live = wb_we_i & (wb_wn_i != 5'd0);

  // Buffer accepts a new LU result only when empty and out of reset.
  assign lu_ready_o = (state_q == S_IDLE) & clrn;

  // Results for r0 are handshaken but never stored.
  assign capture = lu_valid_i & lu_ready_o & (lu_wn_i != 5'd0);

  // Buffer FSM: decides when the buffered result takes the write port.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    starve_d    = starve_q;
    commit      = 1'b0;
    pipe_hold_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_PEND;
      end
      S_PEND: begin
        if (!wb_live) begin
          commit   = 1'b1;
          state_d  = S_IDLE;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_q == STARVE_LIM) state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        pipe_hold_o = 1'b1;
        commit      = 1'b1;
        state_d     = S_IDLE;
        starve_d    = '0;
      end
      default: begin
        state_d  = S_IDLE;
        starve_d = '0;
      end
    endcase
  end

  // Write-port mux: a committing buffer owns the port, otherwise WB passes through.
  always_comb begin
    rf_we_o = 1'b0;
    rf_wn_o = wb_wn_i;
    rf_d_o  = wb_d_i;
    if (commit) begin
      rf_we_o = 1'b1;
      rf_wn_o = buf_wn_q;
      rf_d_o  = buf_d_q;
    end else begin
      rf_we_o = wb_live & clrn;
    end
  end

  // Hazard detection against registered busy bits (r0 never busy).
  always_comb begin
    hazard = (id_use_rs_i & busy_q[id_rs_i])
           | (id_use_rt_i & busy_q[id_rt_i])
           | (id_wr_i & busy_q[id_wn_i])
           | (id_wr_i & id_long_i & (cnt_q == CNT_MAX))
           | pipe_hold_o;
    id_stall_o = id_valid_i & hazard & clrn;
  end

  assign issue = id_valid_i & ~id_stall_o & id_wr_i & id_long_i & (id_wn_i != 5'd0);

  // Scoreboard next state: commit frees its register, issue marks a new one.
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[buf_wn_q] = 1'b0;
    if (issue)  busy_d[id_wn_i]  = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (issue && !commit) begin
      cnt_d = cnt_q + 1'b1;
    end else if (commit && !issue && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state: FSM, starvation counter, scoreboard and outstanding count.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      busy_q   <= '0;
      cnt_q    <= '0;
      buf_wn_q <= 5'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      state_q  <= state_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      if (capture) buf_wn_q <= lu_wn_i;
    end
  end

  // Buffer payload register, loaded on capture.
  always_ff @(posedge clk) begin
    // NOTE: the data payload has no reset; it is only observed while the FSM
    // says the buffer is full, and reset forces the FSM to empty.
    if (capture) buf_d_q <= lu_d_i;
  end

  // Protocol checks: no commit without an outstanding op, count stays bounded.
  a_commit_outstanding: assert property (
    @(posedge clk) disable iff (!clrn) !(commit && (cnt_q == '0)));
  a_cnt_bound: assert property (
    @(posedge clk) disable iff (!clrn) cnt_q <= CNT_MAX);
  a_no_r0_busy: assert property (
    @(posedge clk) disable iff (!clrn) busy_q[0] == 1'b0);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (MAX_LONG=4, STARVE_MAX=3).
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_valid, id_use_rs, id_use_rt, id_wr, id_long;
  logic [4:0]  id_rs, id_rt, id_wn;
  logic        id_stall;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        pipe_hold;
  logic        lu_valid;
  logic [4:0]  lu_wn;
  logic [31:0] lu_d;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_wb_sched #(.MAX_LONG(4), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .id_valid_i (id_valid),
    .id_rs_i    (id_rs),
    .id_use_rs_i(id_use_rs),
    .id_rt_i    (id_rt),
    .id_use_rt_i(id_use_rt),
    .id_wr_i    (id_wr),
    .id_wn_i    (id_wn),
    .id_long_i  (id_long),
    .id_stall_o (id_stall),
    .wb_we_i    (wb_we),
    .wb_wn_i    (wb_wn),
    .wb_d_i     (wb_d),
    .pipe_hold_o(pipe_hold),
    .lu_valid_i (lu_valid),
    .lu_wn_i    (lu_wn),
    .lu_d_i     (lu_d),
    .lu_ready_o (lu_ready),
    .rf_we_o    (rf_we),
    .rf_wn_o    (rf_wn),
    .rf_d_o     (rf_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wr = 1'b0; id_long = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_wn = 5'd0;
  endtask

  task automatic clear_all();
    clear_id();
    wb_we = 1'b0; wb_wn = 5'd0; wb_d = 32'd0;
    lu_valid = 1'b0; lu_wn = 5'd0; lu_d = 32'd0;
  endtask

  task automatic set_issue(input logic [4:0] wn);
    clear_id();
    id_valid = 1'b1; id_wr = 1'b1; id_long = 1'b1; id_wn = wn;
  endtask

  task automatic set_read(input logic [4:0] rs);
    clear_id();
    id_valid = 1'b1; id_use_rs = 1'b1; id_rs = rs;
  endtask

  logic [4:0] issue_regs [4] = '{5'd1, 5'd2, 5'd4, 5'd6};
  logic [4:0] drain_regs [4] = '{5'd2, 5'd4, 5'd6, 5'd8};

  initial begin
    // Reset held with active-looking inputs: all outputs must stay low.
    clrn = 1'b0;
    clear_all();
    wb_we = 1'b1; wb_wn = 5'd4; wb_d = 32'h1;
    lu_valid = 1'b1; lu_wn = 5'd3;
    set_issue(5'd2);
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_lu_ready", 32'(lu_ready), 32'd0);
    check("rst_pipe_hold", 32'(pipe_hold), 32'd0);
    check("rst_id_stall", 32'(id_stall), 32'd0);
    #10;
    clear_all();
    clrn = 1'b1;
    tick();
    #1;
    check("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    check("post_rst_rf_we", 32'(rf_we), 32'd0);

    // 1: RAW then WAW stall on r5 until its LU result commits.
    tick();
    set_issue(5'd5);
    #1 check("t1_issue_nostall", 32'(id_stall), 32'd0);
    tick();
    set_read(5'd5);
    #1 check("t1_raw_stall", 32'(id_stall), 32'd1);
    tick();
    clear_id();
    id_valid = 1'b1; id_wr = 1'b1; id_wn = 5'd5;
    lu_valid = 1'b1; lu_wn = 5'd5; lu_d = 32'h0000_0055;
    #1;
    check("t1_waw_stall", 32'(id_stall), 32'd1);
    check("t1_lu_ready", 32'(lu_ready), 32'd1);
    check("t1_no_early_write", 32'(rf_we), 32'd0);
    tick();
    lu_valid = 1'b0;
    #1;
    check("t1_commit_we", 32'(rf_we), 32'd1);
    check("t1_commit_wn", 32'(rf_wn), 32'd5);
    check("t1_commit_d", rf_d, 32'h0000_0055);
    check("t1_stall_on_commit", 32'(id_stall), 32'd1);
    check("t1_full_not_ready", 32'(lu_ready), 32'd0);
    tick();
    #1;
    check("t1_stall_released", 32'(id_stall), 32'd0);
    check("t1_idle_rf_we", 32'(rf_we), 32'd0);
    check("t1_ready_again", 32'(lu_ready), 32'd1);
    tick();
    clear_id();

    // 2: LU r7 = DEADBEEF with WB idle writes one cycle later, then r7 free.
    set_issue(5'd7);
    tick();
    clear_id();
    lu_valid = 1'b1; lu_wn = 5'd7; lu_d = 32'hDEAD_BEEF;
    #1 check("t2_capture_cycle_we", 32'(rf_we), 32'd0);
    tick();
    lu_valid = 1'b0;
    #1;
    check("t2_we", 32'(rf_we), 32'd1);
    check("t2_wn", 32'(rf_wn), 32'd7);
    check("t2_d", rf_d, 32'hDEAD_BEEF);
    tick();
    set_read(5'd7);
    #1 check("t2_r7_free", 32'(id_stall), 32'd0);
    tick();
    clear_id();

    // 3: WB wins three times, fourth cycle forces the buffer and holds the pipe.
    set_issue(5'd3);
    tick();
    clear_id();
    lu_valid = 1'b1; lu_wn = 5'd3; lu_d = 32'h3333_3333;
    wb_we = 1'b1; wb_wn = 5'd10; wb_d = 32'hAAAA_0000;
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_wn = 5'(10 + i); wb_d = 32'hAAAA_0001 + 32'(i);
      #1;
      check("t3_wb_wins_wn", 32'(rf_wn), 32'(10 + i));
      check("t3_wb_wins_d", rf_d, 32'hAAAA_0001 + 32'(i));
      check("t3_no_hold", 32'(pipe_hold), 32'd0);
      tick();
    end
    wb_wn = 5'd13; wb_d = 32'hAAAA_0004;
    id_valid = 1'b1;
    #1;
    check("t3_force_hold", 32'(pipe_hold), 32'd1);
    check("t3_force_we", 32'(rf_we), 32'd1);
    check("t3_force_wn", 32'(rf_wn), 32'd3);
    check("t3_force_d", rf_d, 32'h3333_3333);
    check("t3_force_id_stall", 32'(id_stall), 32'd1);
    check("t3_force_not_ready", 32'(lu_ready), 32'd0);
    tick();
    #1;
    check("t3_after_hold", 32'(pipe_hold), 32'd0);
    check("t3_after_ready", 32'(lu_ready), 32'd1);
    check("t3_after_wb_wn", 32'(rf_wn), 32'd13);
    check("t3_after_id_stall", 32'(id_stall), 32'd0);
    tick();
    clear_all();

    // 4: four long ops fill the limit, fifth stalls until one commits.
    for (int i = 0; i < 4; i++) begin
      set_issue(issue_regs[i]);
      #1 check("t4_issue_ok", 32'(id_stall), 32'd0);
      tick();
    end
    set_issue(5'd8);
    lu_valid = 1'b1; lu_wn = 5'd1; lu_d = 32'h11;
    #1 check("t4_limit_stall", 32'(id_stall), 32'd1);
    tick();
    lu_valid = 1'b0;
    #1;
    check("t4_commit_wn", 32'(rf_wn), 32'd1);
    check("t4_stall_on_commit", 32'(id_stall), 32'd1);
    tick();
    #1 check("t4_fifth_issues", 32'(id_stall), 32'd0);
    tick();
    clear_id();
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1; lu_wn = drain_regs[i]; lu_d = 32'(drain_regs[i]);
      tick();
      lu_valid = 1'b0;
      #1;
      check("t4_drain_we", 32'(rf_we), 32'd1);
      check("t4_drain_wn", 32'(rf_wn), 32'(drain_regs[i]));
      tick();
    end

    // 5: LU and WB targeting r0 never write and never fill the buffer.
    lu_valid = 1'b1; lu_wn = 5'd0; lu_d = 32'hFFFF_FFFF;
    wb_we = 1'b1; wb_wn = 5'd0; wb_d = 32'h1234_5678;
    #1;
    check("t5_r0_no_write", 32'(rf_we), 32'd0);
    check("t5_r0_ready", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    set_read(5'd0);
    #1;
    check("t5_r0_not_buffered", 32'(lu_ready), 32'd1);
    check("t5_r0_no_commit", 32'(rf_we), 32'd0);
    check("t5_r0_not_busy", 32'(id_stall), 32'd0);
    tick();
    clear_all();

    // 6: reset while PEND with r3 busy discards the buffer and clears busy.
    set_issue(5'd3);
    tick();
    clear_id();
    lu_valid = 1'b1; lu_wn = 5'd3; lu_d = 32'h0BAD_0003;
    wb_we = 1'b1; wb_wn = 5'd20; wb_d = 32'h2020;
    tick();
    lu_valid = 1'b0;
    #1 check("t6_pend_not_ready", 32'(lu_ready), 32'd0);
    clrn = 1'b0;
    #1;
    check("t6_rst_rf_we", 32'(rf_we), 32'd0);
    check("t6_rst_lu_ready", 32'(lu_ready), 32'd0);
    #10;
    wb_we = 1'b0;
    clrn = 1'b1;
    tick();
    set_read(5'd3);
    #1;
    check("t6_idle_ready", 32'(lu_ready), 32'd1);
    check("t6_buffer_dropped", 32'(rf_we), 32'd0);
    check("t6_r3_free", 32'(id_stall), 32'd0);
    tick();
    clear_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
